// File: rtl/mem_copy_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_copy_pkg
//  Description : Shared definitions for the memory copy engine: the FSM
//                state encoding and its width.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_copy_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

endpackage : mem_copy_pkg
`default_nettype wire

// File: rtl/mem_copy_engine.sv
`default_nettype none
// ============================================================================
//  Module      : mem_copy_engine
//  Description : Memory initiator that copies LEN words from SRC to DST
//                inside one attached memory, one word at a time with
//                ascending addresses. The read of word n+1 is issued only
//                after write n is accepted, so overlapping ranges behave
//                like a plain sequential ascending copy.
//  Ports       : clk, rst_n (async, active-low)
//                start_i/src_i/dst_i/len_i - command, sampled in IDLE
//                abort_i                   - stop at next word boundary
//                busy_o/done_o/aborted_o/count_o - status
//                rd_addr_o/rd_vld_o/rd_data_i/rd_rdy_i - memory read side
//                wr_addr_o/wr_data_o/wr_vld_o/wr_rdy_i - memory write side
//                fill_i/fill_data_i        - only with MEM_COPY_FILL_EN
//  Config      : MEM_COPY_FILL_EN - adds a fill mode that writes a constant
//                pattern to LEN words from DST without any reads.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_copy_engine
  import mem_copy_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] src_i,
  input  logic [ADDR_W-1:0] dst_i,
  input  logic [ADDR_W:0]   len_i,
  input  logic              abort_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              aborted_o,
  output logic [ADDR_W:0]   count_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic              rd_vld_o,
  input  logic [DATA_W-1:0] rd_data_i,
  input  logic              rd_rdy_i,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic              wr_vld_o,
  input  logic              wr_rdy_i
`ifdef MEM_COPY_FILL_EN
  ,
  input  logic              fill_i,
  input  logic [DATA_W-1:0] fill_data_i
`endif
);

  localparam logic [ADDR_W:0]   C_CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] C_PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  logic [ADDR_W:0]   r_len;
  logic              r_abort_pend;

  logic              w_abort;
  logic              w_wr_hs;
  logic [ADDR_W:0]   w_count_inc;
  logic              w_last;
  logic              w_fill_mode;

  // Read pointer, write pointer and word counter live directly in the
  // output registers.
  assign w_abort     = abort_i | r_abort_pend;
  assign w_wr_hs     = wr_vld_o & wr_rdy_i;
  assign w_count_inc = count_o + C_CNT_ONE;
  assign w_last      = (w_count_inc == r_len);

`ifdef MEM_COPY_FILL_EN
  logic r_fill;
  assign w_fill_mode = r_fill;
`else
  assign w_fill_mode = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_len        <= '0;
      r_abort_pend <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      aborted_o    <= 1'b0;
      count_o      <= '0;
      rd_addr_o    <= '0;
      rd_vld_o     <= 1'b0;
      wr_addr_o    <= '0;
      wr_data_o    <= '0;
      wr_vld_o     <= 1'b0;
`ifdef MEM_COPY_FILL_EN
      r_fill       <= 1'b0;
`endif
    end else begin
      // Abort is a level; remember it so a short pulse seen in any busy
      // state still ends the job at the next word boundary.
      if (abort_i && r_state != ST_IDLE && r_state != ST_DONE)
        r_abort_pend <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            rd_addr_o    <= src_i;
            wr_addr_o    <= dst_i;
            r_len        <= len_i;
            count_o      <= '0;
            r_abort_pend <= 1'b0;
            busy_o       <= 1'b1;
`ifdef MEM_COPY_FILL_EN
            r_fill       <= fill_i;
`endif
            if (len_i == '0) begin
              r_state   <= ST_DONE;
              done_o    <= 1'b1;
              aborted_o <= 1'b0;
            end else begin
`ifdef MEM_COPY_FILL_EN
              if (fill_i) begin
                r_state   <= ST_WR_REQ;
                wr_vld_o  <= 1'b1;
                wr_data_o <= fill_data_i;
              end else begin
                r_state  <= ST_RD_REQ;
                rd_vld_o <= 1'b1;
              end
`else
              r_state  <= ST_RD_REQ;
              rd_vld_o <= 1'b1;
`endif
            end
          end
        end

        ST_RD_REQ: begin
          // Single-cycle request; the read is always followed through so
          // the responder's data beat is consumed even on abort.
          rd_vld_o <= 1'b0;
          r_state  <= ST_RD_WAIT;
        end

        ST_RD_WAIT: begin
          if (rd_rdy_i) begin
            if (w_abort) begin
              r_state   <= ST_DONE;
              done_o    <= 1'b1;
              aborted_o <= 1'b1;
            end else begin
              wr_data_o <= rd_data_i;
              wr_vld_o  <= 1'b1;
              r_state   <= ST_WR_REQ;
            end
          end
        end

        ST_WR_REQ: begin
          if (w_wr_hs) begin
            count_o   <= w_count_inc;
            rd_addr_o <= rd_addr_o + C_PTR_ONE;
            wr_addr_o <= wr_addr_o + C_PTR_ONE;
            // Finishing the last word wins over a simultaneous abort.
            if (w_last || w_abort) begin
              wr_vld_o  <= 1'b0;
              r_state   <= ST_DONE;
              done_o    <= 1'b1;
              aborted_o <= ~w_last;
            end else if (w_fill_mode) begin
              r_state <= ST_WR_REQ;
            end else begin
              wr_vld_o <= 1'b0;
              rd_vld_o <= 1'b1;
              r_state  <= ST_RD_REQ;
            end
          end
        end

        ST_DONE: begin
          done_o    <= 1'b0;
          aborted_o <= 1'b0;
          busy_o    <= 1'b0;
          r_state   <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : mem_copy_engine
`default_nettype wire

// File: tb/tb_mem_copy_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_copy_engine
//  Description : Directed self-checking bench for mem_copy_engine with a
//                behavioural 256-word memory responder (1-cycle read latency).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_copy_engine;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] src;
  logic [7:0] dst;
  logic [8:0] len;
  logic       abort;
  logic       busy;
  logic       done;
  logic       aborted;
  logic [8:0] count;
  logic [7:0] rd_addr;
  logic       rd_vld;
  logic [7:0] rd_data;
  logic       rd_rdy;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_vld;
  logic       wr_rdy;
`ifdef MEM_COPY_FILL_EN
  logic       fill;
  logic [7:0] fill_data;
`endif

  logic [7:0] mem [256];
  logic [7:0] rd_log[$];
  logic [7:0] wr_log[$];
  int         overlap_cnt;
  int         n_tests;
  int         n_fail;

  mem_copy_engine #(.DATA_W(8), .ADDR_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start),
    .src_i     (src),
    .dst_i     (dst),
    .len_i     (len),
    .abort_i   (abort),
    .busy_o    (busy),
    .done_o    (done),
    .aborted_o (aborted),
    .count_o   (count),
    .rd_addr_o (rd_addr),
    .rd_vld_o  (rd_vld),
    .rd_data_i (rd_data),
    .rd_rdy_i  (rd_rdy),
    .wr_addr_o (wr_addr),
    .wr_data_o (wr_data),
    .wr_vld_o  (wr_vld),
    .wr_rdy_i  (wr_rdy)
`ifdef MEM_COPY_FILL_EN
    ,
    .fill_i      (fill),
    .fill_data_i (fill_data)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory responder plus transaction logs.
  always @(posedge clk) begin
    rd_rdy <= rd_vld;
    if (rd_vld) begin
      rd_data <= mem[rd_addr];
      rd_log.push_back(rd_addr);
    end
    if (wr_vld && wr_rdy) begin
      mem[wr_addr] <= wr_data;
      wr_log.push_back(wr_addr);
    end
    if (rd_vld && wr_vld) overlap_cnt <= overlap_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Leaves the caller on the falling edge just after the start was sampled.
  task automatic start_job(input logic [7:0] s, input logic [7:0] d, input logic [8:0] l);
    @(negedge clk);
    rd_log.delete();
    wr_log.delete();
    src   = s;
    dst   = d;
    len   = l;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int cyc);
    cyc = 0;
    while (!done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check_val({tag, "_done_seen"}, 32'(done), 32'd1);
  endtask

  task automatic wait_wr_vld(input string tag);
    int n;
    n = 0;
    while (!wr_vld && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, "_wr_vld_seen"}, 32'(wr_vld), 32'd1);
  endtask

  int cyc;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    overlap_cnt = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    wr_rdy = 1'b1;
    rd_rdy = 1'b0;
    rd_data = 8'h00;
    src = 8'h00;
    dst = 8'h00;
    len = 9'd0;
`ifdef MEM_COPY_FILL_EN
    fill = 1'b0;
    fill_data = 8'h00;
`endif
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'hA1; mem[8'h11] = 8'hA2; mem[8'h12] = 8'hA3; mem[8'h13] = 8'hA4;
    mem[8'hFE] = 8'h11; mem[8'hFF] = 8'h22; mem[8'h00] = 8'h33; mem[8'h01] = 8'h44;
    mem[8'h20] = 8'h55; mem[8'h21] = 8'h66; mem[8'h22] = 8'h77; mem[8'h23] = 8'h88;
    mem[8'h91] = 8'hEE;

    repeat (3) @(negedge clk);
    check_val("rst_busy",    32'(busy),    32'd0);
    check_val("rst_done",    32'(done),    32'd0);
    check_val("rst_rd_vld",  32'(rd_vld),  32'd0);
    check_val("rst_wr_vld",  32'(wr_vld),  32'd0);
    check_val("rst_count",   32'(count),   32'd0);
    check_val("rst_wr_data", 32'(wr_data), 32'd0);
    rst_n = 1'b1;

    // Basic 4-word copy, 3 cycles per word.
    start_job(8'h10, 8'h80, 9'd4);
    check_val("t1_busy_first", 32'(busy),    32'd1);
    check_val("t1_rd_vld",     32'(rd_vld),  32'd1);
    check_val("t1_rd_addr",    32'(rd_addr), 32'h10);
    wait_done("t1", cyc);
    check_val("t1_cycles",  32'(cyc),     32'd12);
    check_val("t1_aborted", 32'(aborted), 32'd0);
    check_val("t1_count",   32'(count),   32'd4);
    check_val("t1_m80", 32'(mem[8'h80]), 32'hA1);
    check_val("t1_m81", 32'(mem[8'h81]), 32'hA2);
    check_val("t1_m82", 32'(mem[8'h82]), 32'hA3);
    check_val("t1_m83", 32'(mem[8'h83]), 32'hA4);
    @(negedge clk);
    check_val("t1_busy_after", 32'(busy), 32'd0);
    check_val("t1_count_held", 32'(count), 32'd4);

    // Zero-length job: immediate completion, no memory traffic.
    start_job(8'h10, 8'h80, 9'd0);
    wait_done("t2", cyc);
    check_val("t2_cycles",  32'(cyc),           32'd0);
    check_val("t2_busy",    32'(busy),          32'd1);
    check_val("t2_aborted", 32'(aborted),       32'd0);
    check_val("t2_count",   32'(count),         32'd0);
    check_val("t2_reads",   32'(rd_log.size()), 32'd0);
    check_val("t2_writes",  32'(wr_log.size()), 32'd0);

    // Source pointer wraps from 0xFF to 0x00.
    start_job(8'hFE, 8'h40, 9'd4);
    wait_done("t3", cyc);
    check_val("t3_nreads", 32'(rd_log.size()), 32'd4);
    check_val("t3_rd0", 32'(rd_log[0]), 32'hFE);
    check_val("t3_rd1", 32'(rd_log[1]), 32'hFF);
    check_val("t3_rd2", 32'(rd_log[2]), 32'h00);
    check_val("t3_rd3", 32'(rd_log[3]), 32'h01);
    check_val("t3_wr0", 32'(wr_log[0]), 32'h40);
    check_val("t3_wr3", 32'(wr_log[3]), 32'h43);
    check_val("t3_m40", 32'(mem[8'h40]), 32'h11);
    check_val("t3_m42", 32'(mem[8'h42]), 32'h33);
    check_val("t3_m43", 32'(mem[8'h43]), 32'h44);

    // Overlapping forward copy replicates the first word.
    start_job(8'h20, 8'h21, 9'd3);
    wait_done("t4", cyc);
    check_val("t4_m21", 32'(mem[8'h21]), 32'h55);
    check_val("t4_m22", 32'(mem[8'h22]), 32'h55);
    check_val("t4_m23", 32'(mem[8'h23]), 32'h55);

    // Write back-pressure, abort raised while stalled.
    wr_rdy = 1'b0;
    start_job(8'h10, 8'h90, 9'd4);
    wait_wr_vld("t5");
    for (int i = 0; i < 5; i++) begin
      if (i == 2) abort = 1'b1;
      @(negedge clk);
      check_val("t5_stall_vld",  32'(wr_vld),  32'd1);
      check_val("t5_stall_addr", 32'(wr_addr), 32'h90);
      check_val("t5_stall_data", 32'(wr_data), 32'hA1);
      check_val("t5_stall_rd",   32'(rd_vld),  32'd0);
    end
    wr_rdy = 1'b1;
    wait_done("t5", cyc);
    check_val("t5_cycles",  32'(cyc),        32'd1);
    check_val("t5_aborted", 32'(aborted),    32'd1);
    check_val("t5_count",   32'(count),      32'd1);
    check_val("t5_m90",     32'(mem[8'h90]), 32'hA1);
    check_val("t5_m91",     32'(mem[8'h91]), 32'hEE);
    abort = 1'b0;

    // Abort coinciding with the final write: job reported complete.
    wr_rdy = 1'b0;
    start_job(8'h11, 8'hB0, 9'd1);
    wait_wr_vld("t6");
    abort = 1'b1;
    @(negedge clk);
    wr_rdy = 1'b1;
    wait_done("t6", cyc);
    check_val("t6_aborted", 32'(aborted),    32'd0);
    check_val("t6_count",   32'(count),      32'd1);
    check_val("t6_mB0",     32'(mem[8'hB0]), 32'hA2);
    abort = 1'b0;

    // Abort held through start (ignored in IDLE), seen in RD_REQ.
    @(negedge clk);
    abort = 1'b1;
    start_job(8'h10, 8'hC0, 9'd3);
    wait_done("t7", cyc);
    check_val("t7_cycles",  32'(cyc),           32'd2);
    check_val("t7_aborted", 32'(aborted),       32'd1);
    check_val("t7_count",   32'(count),         32'd0);
    check_val("t7_writes",  32'(wr_log.size()), 32'd0);
    check_val("t7_reads",   32'(rd_log.size()), 32'd1);
    abort = 1'b0;

    // Reset in the middle of a job.
    start_job(8'h10, 8'hD0, 9'd4);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("t8_busy",   32'(busy),   32'd0);
    check_val("t8_count",  32'(count),  32'd0);
    check_val("t8_wr_vld", 32'(wr_vld), 32'd0);
    check_val("t8_rd_vld", 32'(rd_vld), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef MEM_COPY_FILL_EN
    fill = 1'b1;
    fill_data = 8'hA5;
    start_job(8'h33, 8'h00, 9'd256);
    fill = 1'b0;
    wait_done("t9", cyc);
    check_val("t9_cycles", 32'(cyc),           32'd256);
    check_val("t9_count",  32'(count),         32'd256);
    check_val("t9_reads",  32'(rd_log.size()), 32'd0);
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== 8'hA5) bad++;
      check_val("t9_bad_words", 32'(bad), 32'd0);
    end
`endif

    check_val("rd_wr_overlap", 32'(overlap_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_mem_copy_engine
`default_nettype wire
